// File: rtl/nn_pkg.sv
// Shared FSM encoding and default sizing for the ALU-to-memory writeback block.
package nn_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; head reads as zero while empty so the write data bus idles low.
module wb_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign head  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage write and pointer advance; push and pop may occur together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mem_writeback.sv
// Collects a counted job of ALU results and writes them to sequential memory addresses.
module alu_mem_writeback
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = ADDR_W + 1;

  wb_state_e         r_state;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_acc_cnt;
  logic [CW-1:0]     r_wr_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_active;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_acc_nxt;
  logic [CW-1:0]     w_wr_nxt;

  // Handshakes: no pass-through when full, writes only while a job is active.
  assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign alu_ready = (r_state == ST_RUN) && !w_full && (r_acc_cnt < r_count);
  assign w_push    = alu_valid && alu_ready;
  assign mem_we    = w_active && !w_empty && mem_ready;
  assign w_pop     = mem_we;
  assign w_acc_nxt = r_acc_cnt + CW'(w_push);
  assign w_wr_nxt  = r_wr_cnt + CW'(w_pop);

  assign mem_addr  = r_addr;
  assign mem_wdata = w_head;
  assign busy      = r_busy;
  assign done      = r_done;

  wb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (alu_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  // Job FSM with counters, write address and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_wr_cnt <= w_wr_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count   <= count;
            r_addr    <= base_addr;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            if (count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_acc_cnt <= w_acc_nxt;
          if (w_acc_nxt == r_count) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_wr_nxt == r_count) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mem_writeback.sv
// Directed bench for alu_mem_writeback with a queue-based write scoreboard.
module tb_alu_mem_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        alu_valid;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;

  int          n_vec;
  int          n_err;
  int          cyc;
  logic [25:0] exp_q [$];

  alu_mem_writeback #(
    .DATA_W (16),
    .ADDR_W (10),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .alu_valid (alu_valid),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: every memory write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [25:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[25:16]));
        chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // Runs one job: preloads expected writes, streams data, holds mem_ready low for blk cycles.
  task automatic run_job(input logic [9:0] base, input logic [10:0] cnt, input logic [15:0] d0,
                         input int blk, input int restart_at, input string tag,
                         output int c0, output int first_wr, output int last_wr,
                         output int done_cyc, output int acc_rel, output bit busy_seen);
    int          idx;
    int          k;
    int          post;
    int          n_wr;
    int          done_n;
    logic [9:0]  a;
    a = base;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back({a, 16'(d0 + 16'(i))});
      a = a + 10'd1;
    end
    first_wr = -1; last_wr = -1; done_cyc = -1; acc_rel = -1; busy_seen = 1'b0;
    idx = 0; k = 0; post = 0; n_wr = 0; done_n = 0;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    alu_valid = 1'b0;
    mem_ready = (blk == 0);
    c0 = cyc;
    tick();
    start     = 1'b0;
    alu_valid = (idx < int'(cnt));
    alu_data  = d0 + 16'(idx);
    while (k < 200 && post < 3) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (alu_valid && alu_ready) idx++;
      if (mem_we) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (done_n > 0) post++;
      tick();
      k++;
      if (k == blk) acc_rel = idx;
      start     = (k == restart_at);
      base_addr = 10'h3C0;
      count     = 11'd9;
      mem_ready = (k >= blk);
      alu_valid = (idx < int'(cnt));
      alu_data  = d0 + 16'(idx);
    end
    start = 1'b0;
    alu_valid = 1'b0;
    if (done_n == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, k);
    end
    chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({tag, "_writes"},      32'(n_wr),   32'(cnt));
    chk({tag, "_sb_empty"},    32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int c0, fw, lw, dc, ar;
    bit bs;
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    alu_valid = 1'b0; alu_data = '0; mem_ready = 1'b0;
    tick();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Streaming job: writes back-to-back, one-cycle latency, done right after last write.
    run_job(10'h010, 11'd4, 16'd1, 0, -1, "stream", c0, fw, lw, dc, ar, bs);
    chk("stream_first_wr", 32'(fw - c0), 32'd2);
    chk("stream_last_wr",  32'(lw - c0), 32'd5);
    chk("stream_done",     32'(dc - c0), 32'd6);
    chk("stream_busy_seen", 32'(bs), 32'd1);
    tick();

    // Back-pressure: only DEPTH words accepted while memory stalls.
    run_job(10'h040, 11'd6, 16'h0100, 8, -1, "stall", c0, fw, lw, dc, ar, bs);
    chk("stall_accepts", 32'(ar), 32'd4);
    tick();

    // Empty job: done one cycle after start, never busy.
    run_job(10'h080, 11'd0, 16'h0000, 0, -1, "zero", c0, fw, lw, dc, ar, bs);
    chk("zero_done", 32'(dc - c0), 32'd1);
    chk("zero_busy", 32'(bs), 32'd0);
    tick();

    // Address wrap at the top of the address space.
    run_job(10'h3FE, 11'd4, 16'h0A00, 0, -1, "wrap", c0, fw, lw, dc, ar, bs);
    tick();

    // Reset mid-job after two accepted words with memory stalled.
    start = 1'b1; base_addr = 10'h100; count = 11'd5; mem_ready = 1'b0;
    tick();
    start = 1'b0; alu_valid = 1'b1; alu_data = 16'h00A1;
    tick();
    alu_data = 16'h00A2;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("midrst_no_we", 32'(mem_we), 32'd0);
    tick();
    run_job(10'h200, 11'd3, 16'h0050, 0, -1, "after_rst", c0, fw, lw, dc, ar, bs);
    tick();

    // Restart pulse while busy must not disturb the running job.
    run_job(10'h020, 11'd3, 16'h0700, 0, 1, "restart", c0, fw, lw, dc, ar, bs);
    @(negedge clk);
    chk("restart_idle_busy", 32'(busy), 32'd0);
    chk("restart_idle_we",   32'(mem_we), 32'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
